// File: rtl/kernel_fifo_src.sv
// kernel_fifo_src: read-side ap_fifo stream source for HLS kernels.
// Each ap_start replays one ROM dataset through a 2-entry prefetch buffer.
module kernel_fifo_src #(
    parameter int  DOUT_WIDTH     = 32,
    parameter int  DATA_SIZE      = 64,
    parameter int  DATASET_NUM    = 8,
    parameter int  ROM_ADDR_WIDTH = 9,
    parameter int  RUN_UPDATE_INV = 1,
    parameter      ROM_INIT_FILE  = "",
    localparam int DS_W = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1,
    localparam int WL_W = $clog2(DATA_SIZE) + 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic                  ap_done,
    output logic [DOUT_WIDTH-1:0] src_dout,
    output logic                  src_empty_n,
    input  logic                  src_read,
    output logic [DS_W-1:0]       dataset_idx,
    output logic [WL_W-1:0]       words_left,
    output logic                  underflow_err,
    output logic                  early_done,
    output logic [1:0]            state_dbg
);

    localparam int ROM_DEPTH = DATA_SIZE * DATASET_NUM;
    localparam int RC_W      = (RUN_UPDATE_INV > 1) ? $clog2(RUN_UPDATE_INV) : 1;

    // Handshake: the head word src_dout is valid while src_empty_n=1; it is
    // consumed on an edge where src_read=1 and src_empty_n=1, and a read while
    // src_empty_n=0 is dropped (recorded in underflow_err).
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [DOUT_WIDTH-1:0]     rom_mem [ROM_DEPTH];
    logic [DOUT_WIDTH-1:0]     rom_q;
    logic                      rd_pending;
    logic [DOUT_WIDTH-1:0]     buf1;
    logic [1:0]                buf_cnt;
    logic [ROM_ADDR_WIDTH-1:0] fetch_ptr;
    logic [WL_W-1:0]           fetched;
    logic [RC_W-1:0]           run_cnt;

    logic                      pop;
    logic                      push;
    logic                      issue;
    logic                      run_done;
    logic [2:0]                occ_after;
    logic [1:0]                cnt_next;
    logic [ROM_ADDR_WIDTH-1:0] base_addr;

    if (ROM_INIT_FILE == "") begin : g_rom_addr_pattern
        // Each ROM word holds its own address, so dataset k word i reads k*DATA_SIZE+i.
        for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_word
            assign rom_mem[a] = DOUT_WIDTH'(a);
        end
    end else begin : g_rom_image
        // rom_mem is loaded from ROM_INIT_FILE by the implementation memory-init step.
    end

    assign pop       = src_read && src_empty_n;
    assign push      = rd_pending;
    assign occ_after = 3'(buf_cnt) + 3'(rd_pending) - 3'(pop);
    assign issue     = (state == STREAM) && !ap_done &&
                       (fetched < WL_W'(DATA_SIZE)) && (occ_after < 3'd2);
    assign run_done  = ((state == STREAM) || (state == WAIT_DONE)) && ap_done;
    assign cnt_next  = buf_cnt + 2'(push) - 2'(pop);
    assign base_addr = ROM_ADDR_WIDTH'(DATA_SIZE * int'(dataset_idx));
    assign state_dbg = state;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            rom_q         <= '0;
            rd_pending    <= 1'b0;
            buf1          <= '0;
            buf_cnt       <= '0;
            fetch_ptr     <= '0;
            fetched       <= '0;
            run_cnt       <= '0;
            src_dout      <= '0;
            src_empty_n   <= 1'b0;
            dataset_idx   <= '0;
            words_left    <= '0;
            underflow_err <= 1'b0;
            early_done    <= 1'b0;
        end else begin
            if (src_read && !src_empty_n) begin
                underflow_err <= 1'b1;
            end

            if (run_done) begin
                if (run_cnt == RC_W'(RUN_UPDATE_INV - 1)) begin
                    run_cnt     <= '0;
                    dataset_idx <= (dataset_idx == DS_W'(DATASET_NUM - 1)) ?
                                   '0 : dataset_idx + DS_W'(1);
                end else begin
                    run_cnt <= run_cnt + RC_W'(1);
                end
            end

            rd_pending <= issue;
            if (issue) begin
                rom_q     <= rom_mem[fetch_ptr];
                fetch_ptr <= fetch_ptr + ROM_ADDR_WIDTH'(1);
                fetched   <= fetched + WL_W'(1);
            end

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state      <= STREAM;
                        words_left <= WL_W'(DATA_SIZE);
                        fetch_ptr  <= base_addr;
                        fetched    <= '0;
                    end
                end
                STREAM: begin
                    if (ap_done) begin
                        // Early completion: drop buffered and in-flight words.
                        early_done  <= 1'b1;
                        words_left  <= '0;
                        buf_cnt     <= '0;
                        src_empty_n <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        case ({pop, push})
                            2'b01: begin
                                if (buf_cnt == 2'd0) src_dout <= rom_q;
                                else                 buf1     <= rom_q;
                            end
                            2'b10: begin
                                if (buf_cnt == 2'd2) src_dout <= buf1;
                            end
                            2'b11: begin
                                if (buf_cnt == 2'd2) begin
                                    src_dout <= buf1;
                                    buf1     <= rom_q;
                                end else begin
                                    src_dout <= rom_q;
                                end
                            end
                            default: ;
                        endcase
                        buf_cnt     <= cnt_next;
                        src_empty_n <= (cnt_next != 2'd0);
                        if (pop) begin
                            words_left <= words_left - WL_W'(1);
                            if (words_left == WL_W'(1)) state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (ap_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
